// File: rtl/cache_perf_monitor.sv
// Performance monitor for the pipelined CPU's I-cache. Counts cycles, retired
// instructions (with jump squash slots removed), I-cache misses, stall cycles
// and generic external events. On the halting system call it freezes the
// counters and computes the I-cache hit rate with a restoring divider.
//
// state | meaning
// IDLE  | waiting for enable; nothing counts
// RUN   | counting gated cycles until the halt instruction retires
// DIV   | one setup cycle, then HR_FRAC divider iterations
// DONE  | counters frozen, hit_rate_q valid
module cache_perf_monitor #(
  parameter int          CNT_W       = 32,
  parameter int          N_EXT       = 2,
  parameter int          HR_FRAC     = 16,
  parameter int          JUMP_SQUASH = 2,
  parameter logic [31:0] SYSCALL     = 32'h0000000c
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  ic_stall,
  input  logic [31:0]           ic_instr,
  input  logic [N_EXT-1:0]      ext_evt,
  input  logic [3:0]            rd_sel,
  output logic [CNT_W-1:0]      rd_data,
  output logic [4+N_EXT-1:0]    ovf,
  output logic                  running,
  output logic                  done,
  output logic [HR_FRAC-1:0]    hit_rate_q
);

  localparam int NUM  = 4 + N_EXT;
  localparam int SQ_W = (JUMP_SQUASH < 1) ? 1 : $clog2(JUMP_SQUASH + 1);
  localparam int ST_W = $clog2(HR_FRAC + 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [SQ_W-1:0]  SQ_LOAD   = SQ_W'(JUMP_SQUASH);
  localparam logic [ST_W-1:0]  LAST_STEP = ST_W'(HR_FRAC);

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt [NUM];
  logic [NUM-1:0]     inc;
  logic [SQ_W-1:0]    sq;
  logic               prev_stall;
  logic               gated, halt, is_jump;
  logic [5:0]         opcode, funct;
  logic [CNT_W-1:0]   rd_mux;

  logic [ST_W-1:0]    step;
  logic [CNT_W:0]     rem, rem_sh, rem_nxt, den_x;
  logic [CNT_W-1:0]   den;
  logic [HR_FRAC-1:0] quo, quo_nxt, sp_val;
  logic               sp, qbit;

  // Event decode for the current cycle. The halt cycle always counts as an
  // instruction, even if it lands in a squash slot: it is the last retirement.
  always_comb begin
    opcode  = ic_instr[31:26];
    funct   = ic_instr[5:0];
    gated   = (state == RUN) && enable;
    is_jump = (opcode == 6'b000010) || (opcode == 6'b000011) ||
              ((opcode == 6'b000000) && (funct == 6'b001000));
    halt    = gated && !ic_stall && (ic_instr == SYSCALL);
    inc     = '0;
    inc[0]  = gated;
    inc[1]  = gated && !ic_stall && (halt || (sq == '0));
    inc[2]  = gated && ic_stall && !prev_stall;
    inc[3]  = gated && ic_stall;
    for (int k = 0; k < N_EXT; k++) inc[4+k] = gated && ext_evt[k];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state_nxt = RUN;
        RUN:     if (halt) state_nxt = DIV;
        DIV:     if (step == LAST_STEP) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Squash slots after a retired jump; a jump inside the window reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq <= '0;
    end else if (clear) begin
      sq <= '0;
    end else if (gated && !ic_stall) begin
      if (is_jump)         sq <= SQ_LOAD;
      else if (sq != '0)   sq <= sq - 1'b1;
    end
  end

  // Stall history for miss edge detection; only advances on gated cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 prev_stall <= 1'b0;
    else if (clear)          prev_stall <= 1'b0;
    else if (state == IDLE)  prev_stall <= 1'b0;
    else if (gated)          prev_stall <= ic_stall;
  end

  // Saturating counters with sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (inc[i]) begin
          if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // One restoring-division step: shift, trial subtract, emit quotient bit.
  always_comb begin
    rem_sh  = rem << 1;
    den_x   = {1'b0, den};
    qbit    = (rem_sh >= den_x);
    rem_nxt = qbit ? (rem_sh - den_x) : rem_sh;
    quo_nxt = (quo << 1) | HR_FRAC'(qbit);
  end

  // Divider sequencing: step 0 loads operands and resolves the degenerate
  // cases, steps 1..HR_FRAC each produce one quotient bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= '0; rem <= '0; den <= '0; quo <= '0; sp <= 1'b0; sp_val <= '0;
    end else if (clear || (state != DIV)) begin
      step <= '0; rem <= '0; den <= '0; quo <= '0; sp <= 1'b0; sp_val <= '0;
    end else if (step == '0) begin
      rem  <= {1'b0, cnt[1] - cnt[2]};
      den  <= cnt[1];
      quo  <= '0;
      step <= step + 1'b1;
      if ((cnt[1] == '0) || (cnt[2] >= cnt[1])) begin
        sp <= 1'b1; sp_val <= '0;
      end else if (cnt[2] == '0) begin
        sp <= 1'b1; sp_val <= '1;
      end else begin
        sp <= 1'b0; sp_val <= '0;
      end
    end else begin
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      step <= step + 1'b1;
    end
  end

  // Result register: written only on the final iteration, so a reset or
  // clear during DIV never exposes a partial quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   hit_rate_q <= '0;
    else if (clear)                            hit_rate_q <= '0;
    else if ((state == DIV) && (step == LAST_STEP))
      hit_rate_q <= sp ? sp_val : quo_nxt;
  end

  // Read-port select; unused codes read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM; i++) if (rd_sel == 4'(i)) rd_mux = cnt[i];
  end

  // Registered read data, live in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Randomized and directed bench for cache_perf_monitor with a behavioural
// reference model working on plain integers.
module tb_cache_perf_monitor;

  localparam logic [31:0] SYSC = 32'h0000000c;
  localparam logic [31:0] NOP  = 32'h00000000;
  localparam int          FRAC = 16;
  localparam longint      MAXV = 64'h00000000_FFFFFFFF;

  logic        clk = 1'b0;
  logic        rst, clear, enable, ic_stall;
  logic [31:0] ic_instr;
  logic [1:0]  ext_evt;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data;
  logic [5:0]  ovf;
  logic        running, done;
  logic [15:0] hit_rate_q;
  logic [3:0]  rd_data_s;
  logic [5:0]  ovf_s;
  logic        running_s, done_s;
  logic [15:0] hit_rate_q_s;

  int checks = 0;
  int errors = 0;

  // reference model state
  int        m_state;   // 0 idle, 1 run, 2 div, 3 done
  longint    m_cnt [6];
  logic [5:0] m_ovf;
  bit        m_prev;
  int        m_sq;
  int        m_div_left;
  longint    m_hit;

  cache_perf_monitor dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .ic_stall(ic_stall), .ic_instr(ic_instr), .ext_evt(ext_evt),
    .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .running(running),
    .done(done), .hit_rate_q(hit_rate_q)
  );

  cache_perf_monitor #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .ic_stall(ic_stall), .ic_instr(ic_instr), .ext_evt(ext_evt),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .ovf(ovf_s), .running(running_s),
    .done(done_s), .hit_rate_q(hit_rate_q_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_jump(input logic [31:0] w);
    return (w[31:26] == 6'd2) || (w[31:26] == 6'd3) ||
           ((w[31:26] == 6'd0) && (w[5:0] == 6'd8));
  endfunction

  function automatic longint hit_expected();
    if (m_cnt[1] == 0 || m_cnt[2] >= m_cnt[1]) return 0;
    if (m_cnt[2] == 0) return (64'd1 << FRAC) - 1;
    return ((m_cnt[1] - m_cnt[2]) << FRAC) / m_cnt[1];
  endfunction

  task automatic model_clear();
    m_state = 0; m_ovf = '0; m_prev = 0; m_sq = 0; m_div_left = 0; m_hit = 0;
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] == MAXV) m_ovf[i] = 1'b1;
    else m_cnt[i]++;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (clear) begin
      model_clear();
      return;
    end
    case (m_state)
      0: begin
        m_prev = 0;
        if (enable) m_state = 1;
      end
      1: if (enable) begin
        bump(0);
        if (ic_stall) begin
          bump(3);
          if (!m_prev) bump(2);
        end
        for (int k = 0; k < 2; k++) if (ext_evt[k]) bump(4 + k);
        m_prev = ic_stall;
        if (!ic_stall) begin
          if (ic_instr == SYSC) begin
            bump(1);
            m_state = 2;
            m_div_left = FRAC + 1;
          end else if (is_jump(ic_instr)) begin
            if (m_sq == 0) bump(1);
            m_sq = 2;
          end else if (m_sq > 0) begin
            m_sq--;
          end else begin
            bump(1);
          end
        end
      end
      2: begin
        m_div_left--;
        if (m_div_left == 0) begin
          m_state = 3;
          m_hit = hit_expected();
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("running", running, (m_state == 1) ? 1 : 0);
    chk("done", done, (m_state == 3) ? 1 : 0);
    chk("hit_rate_q", hit_rate_q, (m_state == 3) ? m_hit : 0);
  endtask

  task automatic read_cnt(input int idx, output longint val);
    rd_sel = 4'(idx);
    tick();
    val = rd_data;
  endtask

  task automatic check_all_counters();
    longint v;
    for (int i = 0; i < 6; i++) begin
      read_cnt(i, v);
      chk($sformatf("cnt%0d", i), v, m_cnt[i]);
    end
    read_cnt(9, v);
    chk("rd_unused", v, 0);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < FRAC + 10) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic start_run();
    clear = 1'b1; enable = 1'b0; ic_stall = 1'b0; ic_instr = NOP; ext_evt = '0;
    tick();
    clear = 1'b0; enable = 1'b1;
    tick();
  endtask

  task automatic step_in(input logic st, input logic [31:0] w);
    ic_stall = st; ic_instr = w;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    int n;
    rst = 1'b1; clear = 1'b0; enable = 1'b0; ic_stall = 1'b0;
    ic_instr = NOP; ext_evt = '0; rd_sel = '0;
    model_clear();
    #3;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit_rate_q, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic run
    start_run();
    for (int i = 0; i < 5; i++) step_in(1'b0, NOP);
    for (int i = 0; i < 2; i++) step_in(1'b1, NOP);
    for (int i = 0; i < 5; i++) step_in(1'b0, NOP);
    for (int i = 0; i < 2; i++) step_in(1'b1, NOP);
    step_in(1'b0, SYSC);
    ic_instr = NOP;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("done_latency", n, FRAC + 1);
    chk("basic_hit", hit_rate_q, 53620);
    read_cnt(0, v); chk("basic_cycle", v, 15);
    read_cnt(1, v); chk("basic_instr", v, 11);
    read_cnt(2, v); chk("basic_miss", v, 2);
    read_cnt(3, v); chk("basic_stall", v, 4);

    // jump squash
    start_run();
    step_in(1'b0, 32'h08000010);
    for (int i = 0; i < 3; i++) step_in(1'b0, NOP);
    step_in(1'b0, 32'h03E00008);
    step_in(1'b0, NOP);
    step_in(1'b0, SYSC);
    ic_instr = NOP;
    wait_done();
    read_cnt(1, v); chk("squash_instr", v, 4);

    // saturation on the narrow instance
    start_run();
    for (int i = 0; i < 20; i++) step_in(1'(i % 2), NOP);
    enable = 1'b0; ic_stall = 1'b0;
    rd_sel = 4'd0;
    tick();
    chk("sat_cycle", rd_data_s, 15);
    chk("sat_ovf", ovf_s, 6'b000001);
    check_all_counters();

    // zero-miss: halt as the first instruction
    start_run();
    step_in(1'b0, SYSC);
    ic_instr = NOP;
    wait_done();
    read_cnt(1, v); chk("zm_instr", v, 1);
    chk("zm_hit", hit_rate_q, 65535);

    // stalled SYSCALL never halts
    start_run();
    for (int i = 0; i < 6; i++) step_in(1'b1, SYSC);
    chk("stalled_sys_done", done, 0);
    ic_stall = 1'b0; ic_instr = NOP;

    // asynchronous reset in the middle of DIV
    start_run();
    for (int i = 0; i < 4; i++) step_in(1'b0, NOP);
    step_in(1'b1, NOP);
    step_in(1'b0, SYSC);
    ic_instr = NOP; rd_sel = 4'd0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_rd", rd_data, m_cnt[0]);
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("arst_rd_data", rd_data, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_running", running, 0);
    chk("arst_done", done, 0);
    chk("arst_hit", hit_rate_q, 0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;

    // clear while in DONE
    start_run();
    for (int i = 0; i < 3; i++) step_in(1'b0, NOP);
    step_in(1'b0, SYSC);
    ic_instr = NOP;
    wait_done();
    clear = 1'b1; enable = 1'b0;
    tick();
    chk("clr_state", {running, done}, 0);
    clear = 1'b0;
    read_cnt(0, v); chk("clr_cycle", v, 0);
    read_cnt(1, v); chk("clr_instr", v, 0);

    // external events and read port
    start_run();
    ext_evt = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0; ext_evt = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    ext_evt = 2'b00;
    read_cnt(4, v); chk("ext0", v, 3);
    read_cnt(5, v); chk("ext1", v, 3);
    read_cnt(9, v); chk("rd_sel9", v, 0);

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      int len;
      start_run();
      len = $urandom_range(20, 60);
      for (int c = 0; c < len; c++) begin
        int r;
        logic [31:0] w;
        enable = ($urandom_range(0, 5) != 0);
        ic_stall = ($urandom_range(0, 3) == 0);
        ext_evt = 2'($urandom);
        r = $urandom_range(0, 9);
        w = $urandom;
        if (w == SYSC) w = NOP;
        case (r)
          0, 1, 2: w = NOP;
          4: w = {6'd2, 26'($urandom)};
          5: w = {6'd3, 26'($urandom)};
          6: w = {6'd0, 5'($urandom), 15'd0, 6'd8};
          7: begin w = SYSC; ic_stall = 1'b1; end
          default: ;
        endcase
        ic_instr = w;
        tick();
      end
      enable = 1'b1; ext_evt = '0;
      step_in(1'b0, SYSC);
      ic_instr = NOP;
      wait_done();
      check_all_counters();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_perf_monitor.md
# cache_perf_monitor

Synthesizable performance-monitor block for the pipelined CPU with I-cache. It sits beside `top` and observes the I-cache stall flag and the cache output instruction. It counts cycles, retired instructions (corrected for jump squash slots), I-cache miss events, stall cycles and N generic external events. On the halting system call it freezes the counters and computes the I-cache hit rate with a sequential fixed-point divider, so the figure is available on-chip rather than only in a bench.

## Interface
Parameters:
- CNT_W, 32, width of every counter and of `rd_data`; minimum 4.
- N_EXT, 2, number of generic external event inputs; valid range 1..8.
- HR_FRAC, 16, fraction bits of `hit_rate_q`; also the divider iteration count.
- JUMP_SQUASH, 2, number of non-stall cycles after a retired j/jal/jr that are not counted as instructions.
- SYSCALL, 32'h0000000c, instruction word that halts measurement.

Ports:
- clk, in, 1, system clock; all state updates on its rising edge.
- rst, in, 1, reset; **one clock; reset is asynchronous and active-high**.
- clear, in, 1, synchronous clear: zeroes all counters and flags and returns to IDLE.
- enable, in, 1, count enable; while low in RUN, all counters hold.
- ic_stall, in, 1, I-cache stall (miss in progress).
- ic_instr, in, 32, instruction currently presented by the I-cache.
- ext_evt, in, N_EXT, generic event strobes; each high cycle counts once.
- rd_sel, in, 4, counter select for the read port.
- rd_data, out, CNT_W, registered read data.
- ovf, out, 4+N_EXT, sticky per-counter saturation flags, using the same index order as `rd_sel`.
- running, out, 1, high in RUN.
- done, out, 1, high in DONE.
- hit_rate_q, out, HR_FRAC, hit rate in unsigned Q0.HR_FRAC.

## Operation
- States and transitions:
  - IDLE: go to RUN when `enable`=1.
  - RUN: go to DIV on the cycle after the halt cycle.
  - DIV: run HR_FRAC iterations, then go to DONE.
  - DONE: hold until `clear` or `rst`.
- Counting gate: the cycle is in RUN and `enable`=1.
  - cycle_cnt (index 0): +1 every gated cycle.
  - instr_cnt (1): +1 on each gated cycle with `ic_stall`=0, unless the squash counter is nonzero.
  - If the squash counter is nonzero, a gated non-stall cycle decrements it and is not counted as an instruction.
  - Retired jump: a gated non-stall cycle with opcode 000010 (j), opcode 000011 (jal), or opcode 000000 with funct 001000 (jr). It loads the squash counter with JUMP_SQUASH.
  - A jump that arrives while the squash counter is nonzero reloads it.
  - miss_cnt (2): +1 on a gated cycle where `ic_stall` is 1 and was 0 on the previous gated cycle. The previous value clears to 0 in IDLE.
  - stall_cnt (3): +1 per gated cycle with `ic_stall`=1.
  - ext_cnt[k] (4+k): +1 per gated cycle with `ext_evt[k]`=1.
- Halt cycle: a gated cycle with `ic_stall`=0 and `ic_instr`==SYSCALL. That cycle is counted normally (cycle, instruction) and is the last counted cycle.
- Saturation: each counter sticks at 2^CNT_W−1. The matching `ovf` bit sets when an increment is attempted at that maximum; it stays set until `clear` or `rst`.
- Hit-rate divider:
  - Operands: N = instr_cnt − miss_cnt, D = instr_cnt.
  - If D==0 or miss_cnt ≥ instr_cnt, the result is 0.
  - If miss_cnt==0, the result is 2^HR_FRAC−1 (1.0 is not representable).
  - Otherwise the result is floor(N·2^HR_FRAC / D), computed by a restoring divider producing 1 quotient bit per cycle.
  - Divider width: CNT_W+1 bits for the remainder.
- Read port: `rd_data` is registered from the counter selected by `rd_sel`. Unused select values return 0.
- `clear` takes priority over every other event, including the halt cycle and DIV.

## Timing
- Reset values: all counters 0, `ovf`=0, `rd_data`=0, `running`=0, `done`=0, `hit_rate_q`=0, state IDLE.
- IDLE→RUN takes 1 cycle: the cycle in which `enable` is first sampled high is not counted.
- Halt cycle at edge T: counters final at T. State is DIV from T+1. `done`=1 and `hit_rate_q` valid from T+1+HR_FRAC; `hit_rate_q` holds in DONE.
- `rd_data` latency is 1 cycle from `rd_sel`. The read port stays live in every state.
- `rst` asserted mid-DIV or mid-RUN: immediate return to reset values, with no partial result visible.
- `enable` dropped mid-RUN: counters and the squash counter hold, and miss edge detection holds its previous value. The halt condition is not checked.
- `ic_stall` and halt are never simultaneous: a stalled SYSCALL word is not a halt.

## Test plan
- Basic run:
  - Stimulus: `enable`=1; 10 non-stall cycles of NOPs; two 2-cycle `ic_stall` pulses; then SYSCALL non-stalled.
  - Required: cycle=15, instr=11, miss=2, stall=4. `done` rises HR_FRAC+1 cycles after the halt edge, with `hit_rate_q`=53620 (floor(9·65536/11)).
- Jump squash:
  - Stimulus: j, then 3 NOPs, then jr (funct 001000), then 1 NOP, then SYSCALL; no stalls.
  - Required: instr=4.
- Saturation:
  - Stimulus: CNT_W=4; 20 gated cycles.
  - Required: cycle_cnt=15, ovf[0]=1, other ovf bits 0.
- Zero-miss and empty cases:
  - Stimulus 1: SYSCALL as the first instruction, with no stalls.
  - Required 1: instr=1, `hit_rate_q`=65535.
  - Stimulus 2: `clear`, then SYSCALL arriving only under stall.
  - Required 2: no halt occurs; `done` stays 0.
- Reset and clear mid-operation:
  - Stimulus 1: assert `rst` asynchronously 5 cycles into DIV.
  - Required 1: every output returns to 0 at once, with no clock edge needed.
  - Stimulus 2: assert `clear` in DONE.
  - Required 2: IDLE with counters 0 on the next edge.
- External events and read port:
  - Stimulus: N_EXT=2; `ext_evt`=2'b11 for 3 cycles, then `enable`=0 for 4 cycles with `ext_evt`=2'b01.
  - Required: rd_sel=4 gives 3, rd_sel=5 gives 3, rd_sel=9 gives 0, each with 1-cycle read latency.
